// File: rtl/dmem_acu_pkg.sv
// Shared types and constants for the data-memory access unit.
// Widths mirror the core's data path (16-bit data, 16-bit byte address).
package dmem_acu_pkg;

   localparam int DMEM_ACU_DATA_WIDTH   = 16;
   localparam int DMEM_ACU_ADDR_WIDTH   = 16;
   localparam int DMEM_ACU_MEM_OFFSET   = 1;
   localparam int DMEM_ACU_MEM_WORDS    = 1024;
   localparam int DMEM_ACU_LOAD_LATENCY = 3;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ISSUE_RD = 3'd1,
      ISSUE_WR = 3'd2,
      LATCH    = 3'd3,
      RESP     = 3'd4
   } dmem_acu_state_t;

endpackage

// File: rtl/dmem_access_unit.sv
// Requester side of the data-memory port: sequences one load/store at a time into a
// registered-address memory. Optional range check enabled by DMEM_ACU_BOUNDS_CHECK_EN.
module dmem_access_unit
   import dmem_acu_pkg::*;
#(
   parameter int DATA_WIDTH = DMEM_ACU_DATA_WIDTH,
   parameter int ADDR_WIDTH = DMEM_ACU_ADDR_WIDTH,
   parameter int MEM_OFFSET = DMEM_ACU_MEM_OFFSET,
   parameter int MEM_WORDS  = DMEM_ACU_MEM_WORDS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reqValid,
   output logic                  reqReady,
   input  logic                  reqWrite,
   input  logic [ADDR_WIDTH-1:0] reqAddr,
   input  logic [DATA_WIDTH-1:0] reqData,
   output logic                  respValid,
   output logic [DATA_WIDTH-1:0] respData,
   output logic                  respFault,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic [DATA_WIDTH-1:0] memDataIn,
   output logic                  memWrEnable,
   input  logic [DATA_WIDTH-1:0] memDataOut
);

   dmem_acu_state_t       r_state;
   dmem_acu_state_t       w_next;
   logic                  r_req_ready;
   logic                  r_resp_valid;
   logic [DATA_WIDTH-1:0] r_resp_data;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_din;
   logic                  r_mem_we;
   logic                  w_accept;
   logic                  w_fault;

   assign w_accept = reqValid && r_req_ready;

`ifdef DMEM_ACU_BOUNDS_CHECK_EN
   logic [31:0] w_word_idx;
   logic        r_fault;

   assign w_word_idx = 32'(reqAddr) >> MEM_OFFSET;
   assign w_fault    = (w_word_idx >= 32'(MEM_WORDS));
   assign respFault  = r_fault;

   // Fault flag is captured per accepted request and read alongside respValid
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fault <= 1'b0;
      end else if (w_accept) begin
         r_fault <= w_fault;
      end else begin
         r_fault <= r_fault;
      end
   end
`else
   assign w_fault   = 1'b0;
   assign respFault = 1'b0;
`endif

   // Next-state decode; out-of-range requests skip the memory and go straight to RESP
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_fault) begin
                  w_next = RESP;
               end else if (reqWrite) begin
                  w_next = ISSUE_WR;
               end else begin
                  w_next = ISSUE_RD;
               end
            end else begin
               w_next = IDLE;
            end
         end
         ISSUE_RD: w_next = LATCH;
         ISSUE_WR: w_next = IDLE;
         LATCH:    w_next = RESP;
         RESP:     w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // State, handshake flags and memory-side registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_data  <= {DATA_WIDTH{1'b0}};
         r_mem_addr   <= {ADDR_WIDTH{1'b0}};
         r_mem_din    <= {DATA_WIDTH{1'b0}};
         r_mem_we     <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_req_ready  <= (w_next == IDLE);
         r_resp_valid <= (w_next == RESP);
         if (w_accept) begin
            r_mem_addr <= reqAddr;
            r_mem_din  <= reqData;
            r_mem_we   <= reqWrite && !w_fault;
         end else begin
            r_mem_addr <= r_mem_addr;
            r_mem_din  <= r_mem_din;
            r_mem_we   <= 1'b0;
         end
         // memDataOut reflects the address the memory latched at the end of ISSUE_RD
         if (r_state == LATCH) begin
            r_resp_data <= memDataOut;
         end else begin
            r_resp_data <= r_resp_data;
         end
      end
   end

   assign reqReady    = r_req_ready;
   assign respValid   = r_resp_valid;
   assign respData    = r_resp_data;
   assign memAddr     = r_mem_addr;
   assign memDataIn   = r_mem_din;
   assign memWrEnable = r_mem_we;

endmodule
